// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: shares one 8x8 unsigned multiplier among NREQ requesters.
// Round-robin arbitration feeds a two-stage pipeline (operand register, then
// result register) that ends in a single tagged result port with backpressure.
//
// Handshake rules (all ports): a transfer happens on a rising edge where both
// valid and ready are high. A requester keeps req_a/req_b stable while its
// req_valid is high and not yet accepted; req_ready never depends on a
// requester's own data. res_c_o/res_id_o stay stable while res_valid_o is high
// and res_ready_i is low.
module mult_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [8*NREQ-1:0] req_a_i,
  input  logic [8*NREQ-1:0] req_b_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [15:0]       res_c_o,
  output logic [ID_W-1:0]   res_id_o,
  output logic [15:0]       done_count_o,
  output logic [ID_W-1:0]   dbg_ptr_o,
  output logic              dbg_s1_valid_o
);

  // Round-robin pointer: the requester searched first.
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Stage 1: operand register.
  logic            s1_valid_q, s1_valid_d;
  logic [7:0]      s1_a_q, s1_a_d;
  logic [7:0]      s1_b_q, s1_b_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;

  // Stage 2: result register driving the result port.
  logic            res_valid_q, res_valid_d;
  logic [15:0]     res_c_q, res_c_d;
  logic [ID_W-1:0] res_id_q, res_id_d;

  logic [15:0]     done_q, done_d;

  logic            s2_adv, s1_free;
  logic            found;
  logic            accept;
  logic [ID_W-1:0] grant;
  logic [7:0]      sel_a, sel_b;
  logic [15:0]     mul_c;

  assign s2_adv  = !res_valid_q || res_ready_i;
  assign s1_free = !s1_valid_q || s2_adv;

  // The one shared multiplier: unsigned 8x8 -> 16, fed only from stage 1.
  assign mul_c = 16'(s1_a_q) * 16'(s1_b_q);

  // Round-robin search: first look at ptr..NREQ-1, then wrap to 0..ptr-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid_i[i] && (ID_W'(i) >= ptr_q)) begin
        grant = ID_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid_i[i]) begin
        grant = ID_W'(i);
        found = 1'b1;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a = req_a_i[8*i +: 8];
        sel_b = req_b_i[8*i +: 8];
      end
    end
  end

  assign accept = found && s1_free && rst_ni;

  // Only the granted requester sees ready, and only while stage 1 can take it.
  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant] = 1'b1;
  end

  // Next-state for pointer, both pipeline stages and the delivery counter.
  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    res_valid_d = res_valid_q;
    res_c_d     = res_c_q;
    res_id_d    = res_id_q;
    done_d      = done_q;

    if (res_valid_q && res_ready_i) done_d = done_q + 16'd1;

    if (s2_adv) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_c_d  = mul_c;
        res_id_d = s1_id_q;
      end
      // Stage 1 empties as its content moves on; a new accept may refill it.
      s1_valid_d = 1'b0;
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = sel_a;
      s1_b_d     = sel_b;
      s1_id_d    = grant;
      ptr_d      = (grant == ID_W'(NREQ-1)) ? '0 : grant + ID_W'(1);
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
      res_id_q    <= '0;
      done_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_c_q     <= res_c_d;
      res_id_q    <= res_id_d;
      done_q      <= done_d;
    end
  end

  assign res_valid_o    = res_valid_q;
  assign res_c_o        = res_c_q;
  assign res_id_o       = res_id_q;
  assign done_count_o   = done_q;
  assign dbg_ptr_o      = ptr_q;
  assign dbg_s1_valid_o = s1_valid_q;

endmodule
